// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between N_REQ byte producers,
// with a programmable inter-frame gap and a done watchdog.
module uart_tx_scheduler #(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned ID_W           = 2,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                 i_Clock,
   input  logic                 i_reset,
   input  logic [N_REQ-1:0]     i_req_valid,
   input  logic [8*N_REQ-1:0]   i_req_data,
   output logic [N_REQ-1:0]     o_req_ready,
   output logic                 o_TX_DV,
   output logic [7:0]           o_TX_Byte,
   input  logic                 i_TX_Done,
   output logic [ID_W-1:0]      o_grant_id,
   output logic                 o_busy,
   output logic                 o_timeout
);

   localparam int unsigned WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned WD_LAST  = TIMEOUT_CYCLES - 1;
   localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [ID_W-1:0]    last_grant;
   logic [WD_W-1:0]    wd_cnt;
   logic [GAP_W-1:0]   gap_cnt;

   logic [N_REQ-1:0]   ready_nxt;
   logic               dv_nxt;
   logic [7:0]         byte_nxt;
   logic [ID_W-1:0]    grant_nxt;
   logic               busy_nxt;
   logic               timeout_nxt;
   logic [ID_W-1:0]    last_nxt;
   logic [WD_W-1:0]    wd_nxt;
   logic [GAP_W-1:0]   gap_nxt;

   logic               any_valid;
   logic [ID_W-1:0]    sel_id;
   logic [7:0]         sel_data;
   logic               wd_expired;
   logic               gap_last;

   // Round-robin pick: walking the offsets downward lets the nearest set bit after last_grant win.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      any_valid = |i_req_valid;
      sel_id    = '0;
      for (int unsigned i = N_REQ; i > 0; i--) begin
         idx = 32'(last_grant) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (i_req_valid[ID_W'(idx)]) sel_id = ID_W'(idx);
      end
      sel_data = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (sel_id == ID_W'(k)) sel_data = i_req_data[8*k +: 8];
      end
   end

   assign wd_expired = (wd_cnt == WD_W'(WD_LAST));
   assign gap_last   = (gap_cnt == GAP_W'(GAP_LAST));

   // State register
   always_ff @(posedge i_Clock) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic; a done pulse outranks a simultaneous watchdog expiry
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (any_valid) state_nxt = LAUNCH;
         LAUNCH:    state_nxt = WAIT_DONE;
         WAIT_DONE: begin
            if (i_TX_Done)       state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            else if (wd_expired) state_nxt = IDLE;
         end
         GAP:       if (gap_last) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Output and datapath next values, registered below
   always_comb begin
      ready_nxt   = '0;
      dv_nxt      = 1'b0;
      timeout_nxt = 1'b0;
      byte_nxt    = o_TX_Byte;
      grant_nxt   = o_grant_id;
      last_nxt    = last_grant;
      wd_nxt      = wd_cnt;
      gap_nxt     = gap_cnt;
      busy_nxt    = (state_nxt != IDLE);
      unique case (state)
         IDLE: begin
            if (any_valid) begin
               ready_nxt = N_REQ'(1) << sel_id;
               byte_nxt  = sel_data;
               grant_nxt = sel_id;
               last_nxt  = sel_id;
            end
         end
         LAUNCH: begin
            dv_nxt = 1'b1;
            wd_nxt = '0;
         end
         WAIT_DONE: begin
            if (i_TX_Done)       gap_nxt = '0;
            else if (wd_expired) timeout_nxt = 1'b1;
            else                 wd_nxt = wd_cnt + WD_W'(1);
         end
         GAP:     gap_nxt = gap_cnt + GAP_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_reset) begin
         o_req_ready <= '0;
         o_TX_DV     <= 1'b0;
         o_TX_Byte   <= '0;
         o_grant_id  <= '0;
         o_busy      <= 1'b0;
         o_timeout   <= 1'b0;
         last_grant  <= ID_W'(N_REQ - 1);
         wd_cnt      <= '0;
         gap_cnt     <= '0;
      end else begin
         o_req_ready <= ready_nxt;
         o_TX_DV     <= dv_nxt;
         o_TX_Byte   <= byte_nxt;
         o_grant_id  <= grant_nxt;
         o_busy      <= busy_nxt;
         o_timeout   <= timeout_nxt;
         last_grant  <= last_nxt;
         wd_cnt      <= wd_nxt;
         gap_cnt     <= gap_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: instance a uses default gap/watchdog,
// instance b a short watchdog (8) and short gap (3).
module tb_uart_tx_scheduler;

   localparam int GAP_A = 16;
   localparam int GAP_B = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  valid_a, valid_b;
   logic [31:0] data_a, data_b;
   logic        done_a, done_b;
   logic [3:0]  ready_a, ready_b;
   logic        dv_a, dv_b;
   logic [7:0]  byte_a, byte_b;
   logic [1:0]  gid_a, gid_b;
   logic        busy_a, busy_b;
   logic        to_a, to_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.N_REQ(4), .ID_W(2), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(4096)) dut_a (
      .i_Clock(clk), .i_reset(rst), .i_req_valid(valid_a), .i_req_data(data_a),
      .o_req_ready(ready_a), .o_TX_DV(dv_a), .o_TX_Byte(byte_a), .i_TX_Done(done_a),
      .o_grant_id(gid_a), .o_busy(busy_a), .o_timeout(to_a));

   uart_tx_scheduler #(.N_REQ(4), .ID_W(2), .GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(8)) dut_b (
      .i_Clock(clk), .i_reset(rst), .i_req_valid(valid_b), .i_req_data(data_b),
      .o_req_ready(ready_b), .o_TX_DV(dv_b), .o_TX_Byte(byte_b), .i_TX_Done(done_b),
      .o_grant_id(gid_b), .o_busy(busy_b), .o_timeout(to_b));

   // Bounded wait: 0 ready_a, 1 a idle, 2 ready_b, 3 b idle; n = negedges waited
   task automatic wait_for(input int which, output int n);
      bit hit;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         case (which)
            0:       hit = (ready_a != 0);
            1:       hit = !busy_a;
            2:       hit = (ready_b != 0);
            default: hit = !busy_b;
         endcase
      end while (!hit && n < 300);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid_a = '0; valid_b = '0; data_a = '0; data_b = '0; done_a = 1'b0; done_b = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (ready_a !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", ready_a); end
      n_checks++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", dv_a); end
      n_checks++; if (byte_a !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", byte_a); end
      n_checks++; if (gid_a !== 2'd0) begin n_fail++; $display("FAIL reset_gid: got %0d want 0", gid_a); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      n_checks++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", to_a); end
      n_checks++; if ({ready_b, dv_b, byte_b, gid_b, busy_b, to_b} !== 17'b0) begin
         n_fail++; $display("FAIL reset_b: got %h want 0", {ready_b, dv_b, byte_b, gid_b, busy_b, to_b}); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int n;
      valid_a = 4'b0100; data_a = 32'h00A5_0000;
      @(negedge clk);
      n_checks++; if (ready_a !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", ready_a); end
      valid_a = '0;
      @(negedge clk);
      n_checks++; if (ready_a !== 4'b0) begin n_fail++; $display("FAIL single_ready_pulse: got %b want 0000", ready_a); end
      n_checks++; if (dv_a !== 1'b1) begin n_fail++; $display("FAIL single_dv: got %b want 1", dv_a); end
      n_checks++; if (byte_a !== 8'hA5) begin n_fail++; $display("FAIL single_byte: got %h want a5", byte_a); end
      n_checks++; if (gid_a !== 2'd2) begin n_fail++; $display("FAIL single_gid: got %0d want 2", gid_a); end
      @(negedge clk);
      n_checks++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL single_dv_pulse: got %b want 0", dv_a); end
      done_a = 1'b1;
      @(negedge clk);
      done_a = 1'b0;
      wait_for(1, n);
      // GAP occupies the GAP_A cycles after the done cycle; idle shows GAP_A+1 cycles after done
      n_checks++; if (n !== GAP_A) begin n_fail++; $display("FAIL single_gap_len: got %0d want %0d", n, GAP_A); end
   endtask

   task automatic test_round_robin();
      int n;
      logic [3:0] exp_ready;
      logic [7:0] exp_byte;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      valid_a = 4'hF; data_a = 32'h1312_1110;
      for (int f = 0; f < 5; f++) begin
         exp_ready = 4'b0001 << (f % 4);
         exp_byte  = 8'h10 + 8'(f % 4);
         wait_for(0, n);
         if (f > 0) begin
            // n counted from the cycle after done, so ready lands GAP_A+2 cycles after done
            n = n + 1;
            n_checks++; if (n !== GAP_A + 2) begin n_fail++; $display("FAIL rr_gap f%0d: got %0d want %0d", f, n, GAP_A + 2); end
         end
         n_checks++; if (ready_a !== exp_ready) begin n_fail++; $display("FAIL rr_ready f%0d: got %b want %b", f, ready_a, exp_ready); end
         @(negedge clk);
         n_checks++; if (dv_a !== 1'b1) begin n_fail++; $display("FAIL rr_dv f%0d: got %b want 1", f, dv_a); end
         n_checks++; if (byte_a !== exp_byte) begin n_fail++; $display("FAIL rr_byte f%0d: got %h want %h", f, byte_a, exp_byte); end
         repeat (20) @(negedge clk);
         done_a = 1'b1;
         @(negedge clk);
         done_a = 1'b0;
      end
      valid_a = '0;
      wait_for(1, n);
   endtask

   task automatic test_timeout();
      int n;
      valid_b = 4'b0011; data_b = 32'h0000_2221;
      wait_for(2, n);
      n_checks++; if (ready_b !== 4'b0001) begin n_fail++; $display("FAIL to_ready: got %b want 0001", ready_b); end
      valid_b = 4'b0010;
      @(negedge clk);
      n_checks++; if (dv_b !== 1'b1 || byte_b !== 8'h21) begin n_fail++; $display("FAIL to_launch: got dv=%b byte=%h want dv=1 byte=21", dv_b, byte_b); end
      n = 0;
      do begin @(negedge clk); n++; end while (!to_b && n < 50);
      n_checks++; if (n !== 8) begin n_fail++; $display("FAIL to_latency: got %0d want 8", n); end
      n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL to_idle: got busy=%b want 0", busy_b); end
      @(negedge clk);
      n_checks++; if (ready_b !== 4'b0010 || to_b !== 1'b0) begin
         n_fail++; $display("FAIL to_next_grant: got ready=%b to=%b want 0010 0", ready_b, to_b); end
      valid_b = '0;
   endtask

   task automatic test_done_vs_timeout();
      int n;
      @(negedge clk);
      n_checks++; if (dv_b !== 1'b1 || byte_b !== 8'h22) begin n_fail++; $display("FAIL dvt_launch: got dv=%b byte=%h want dv=1 byte=22", dv_b, byte_b); end
      repeat (7) @(negedge clk);
      done_b = 1'b1;
      @(negedge clk);
      done_b = 1'b0;
      n_checks++; if (to_b !== 1'b0) begin n_fail++; $display("FAIL dvt_timeout: got %b want 0", to_b); end
      n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL dvt_gap_busy: got %b want 1", busy_b); end
      wait_for(3, n);
      n_checks++; if (n !== GAP_B) begin n_fail++; $display("FAIL dvt_gap_len: got %0d want %0d", n, GAP_B); end
   endtask

   task automatic test_reset_mid();
      int n;
      valid_a = 4'b1000; data_a = 32'hC300_0000;
      wait_for(0, n);
      n_checks++; if (ready_a !== 4'b1000) begin n_fail++; $display("FAIL rm_ready3: got %b want 1000", ready_a); end
      valid_a = '0;
      @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1; valid_a = 4'hF; data_a = 32'h4433_2211;
      @(negedge clk);
      n_checks++; if ({ready_a, dv_a, byte_a, gid_a, busy_a, to_a} !== 17'b0) begin
         n_fail++; $display("FAIL rm_reset_vals: got %h want 0", {ready_a, dv_a, byte_a, gid_a, busy_a, to_a}); end
      @(negedge clk);
      n_checks++; if (ready_a !== 4'b0 || dv_a !== 1'b0) begin
         n_fail++; $display("FAIL rm_held: got ready=%b dv=%b want 0000 0", ready_a, dv_a); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (ready_a !== 4'b0001 || gid_a !== 2'd0) begin
         n_fail++; $display("FAIL rm_grant0: got ready=%b gid=%0d want 0001 0", ready_a, gid_a); end
      valid_a = '0;
      @(negedge clk);
      n_checks++; if (dv_a !== 1'b1 || byte_a !== 8'h11) begin n_fail++; $display("FAIL rm_launch: got dv=%b byte=%h want dv=1 byte=11", dv_a, byte_a); end
      done_a = 1'b1;
      @(negedge clk);
      done_a = 1'b0;
      wait_for(1, n);
   endtask

   task automatic test_spurious();
      int n;
      done_a = 1'b1;
      @(negedge clk);
      done_a = 1'b0;
      @(negedge clk);
      n_checks++; if (busy_a !== 1'b0 || dv_a !== 1'b0) begin
         n_fail++; $display("FAIL sp_idle: got busy=%b dv=%b want 0 0", busy_a, dv_a); end
      valid_a = 4'b0010; data_a = 32'h0000_5500;
      wait_for(0, n);
      n_checks++; if (ready_a !== 4'b0010) begin n_fail++; $display("FAIL sp_ready: got %b want 0010", ready_a); end
      valid_a = '0;
      @(negedge clk);
      done_a = 1'b1;
      @(negedge clk);
      done_a = 1'b0;
      @(negedge clk);
      done_a = 1'b1;
      @(negedge clk);
      done_a = 1'b0;
      n_checks++; if (busy_a !== 1'b1 || dv_a !== 1'b0) begin
         n_fail++; $display("FAIL sp_gap: got busy=%b dv=%b want 1 0", busy_a, dv_a); end
      wait_for(1, n);
      // A done pulse during GAP must not shorten or restart it
      n_checks++; if (n !== GAP_A - 2) begin n_fail++; $display("FAIL sp_gap_len: got %0d want %0d", n, GAP_A - 2); end
      n_checks++; if (gid_a !== 2'd1 || byte_a !== 8'h55) begin
         n_fail++; $display("FAIL sp_hold: got gid=%0d byte=%h want 1 55", gid_a, byte_a); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_done_vs_timeout();
      test_reset_mid();
      test_spurious();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
